// File: rtl/pipe_pkg.sv
// Shared widths, control-bundle bit positions and packet sizing for pipeline-stage latches.
package pipe_pkg;

   localparam int PIPE_DATA_W   = 16;
   localparam int PIPE_NUM_DATA = 4;
   localparam int PIPE_CTRL_W   = 11;
   localparam int PIPE_REG_W    = 3;

   // Bit positions inside the control bundle carried alongside the data lanes.
   localparam int CTRL_REGWRITE  = 0;
   localparam int CTRL_DMEMWRITE = 1;
   localparam int CTRL_DMEMEN    = 2;
   localparam int CTRL_MEMTOREG  = 3;
   localparam int CTRL_DMEMDUMP  = 4;
   localparam int CTRL_BRANCH    = 5;
   localparam int CTRL_JUMP      = 6;
   localparam int CTRL_BRPCEN    = 7;
   localparam int CTRL_BORJ      = 8;
   localparam int CTRL_RDRS      = 9;
   localparam int CTRL_RDRT      = 10;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_t;

   function automatic int pkt_w(input int num_data, input int data_w,
                                input int ctrl_w, input int reg_w);
      return num_data * data_w + ctrl_w + reg_w;
   endfunction

   localparam int PIPE_PKT_W = pkt_w(PIPE_NUM_DATA, PIPE_DATA_W, PIPE_CTRL_W, PIPE_REG_W);

endpackage

// File: rtl/pipe_entry_reg.sv
// One packet slot: payload register with load enable plus a valid bit updated every cycle.
module pipe_entry_reg #(
   parameter int PKT_W = 78
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             valid_nxt,
   input  logic [PKT_W-1:0] data_nxt,
   output logic             valid,
   output logic [PKT_W-1:0] data
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= 1'b0;
         data  <= '0;
      end else begin
         valid <= valid_nxt;
         if (load) begin
            data <= data_nxt;
         end
      end
   end

endmodule

// File: rtl/pipe_stage_latch.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer and synchronous flush.
module pipe_stage_latch
   import pipe_pkg::*;
#(
   parameter int DATA_W   = PIPE_DATA_W,
   parameter int NUM_DATA = PIPE_NUM_DATA,
   parameter int CTRL_W   = PIPE_CTRL_W,
   parameter int REG_W    = PIPE_REG_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NUM_DATA*DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0]          in_ctrl,
   input  logic [REG_W-1:0]           in_wreg,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_DATA*DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0]          out_ctrl,
   output logic [REG_W-1:0]           out_wreg,
   output logic [1:0]                 occupancy
);

   // Handshake: a packet moves across a port on a rising edge where valid and ready
   // are both high; in_ready comes straight from the skid valid flop, never from out_ready.

   localparam int LANES_W = NUM_DATA * DATA_W;
   localparam int PKT_W   = pkt_w(NUM_DATA, DATA_W, CTRL_W, REG_W);

   logic             main_valid, skid_valid;
   logic             main_valid_nxt, skid_valid_nxt;
   logic             main_load, skid_load, main_from_skid;
   logic             acc, drain;
   logic [PKT_W-1:0] in_pkt, main_pkt, skid_pkt, main_d;
   occ_t             occ;

   assign in_pkt   = {in_data, in_ctrl, in_wreg};
   assign in_ready = !skid_valid;
   assign acc      = in_valid & in_ready;
   assign drain    = main_valid & out_ready;

   always_comb begin
      main_valid_nxt = main_valid;
      skid_valid_nxt = skid_valid;
      main_load      = 1'b0;
      skid_load      = 1'b0;
      main_from_skid = 1'b0;
      if (flush) begin
         main_valid_nxt = 1'b0;
         skid_valid_nxt = 1'b0;
      end else if (skid_valid) begin
         // in_ready is low here, so nothing can be accepted alongside the skid move.
         if (drain) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            main_valid_nxt = 1'b1;
            skid_valid_nxt = 1'b0;
         end
      end else if (!main_valid || drain) begin
         main_load      = acc;
         main_valid_nxt = acc;
      end else if (acc) begin
         skid_load      = 1'b1;
         skid_valid_nxt = 1'b1;
      end
   end

   assign main_d = main_from_skid ? skid_pkt : in_pkt;

   pipe_entry_reg #(.PKT_W(PKT_W)) u_main (
      .clk       (clk),
      .rst       (rst),
      .load      (main_load),
      .valid_nxt (main_valid_nxt),
      .data_nxt  (main_d),
      .valid     (main_valid),
      .data      (main_pkt)
   );

   pipe_entry_reg #(.PKT_W(PKT_W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .load      (skid_load),
      .valid_nxt (skid_valid_nxt),
      .data_nxt  (in_pkt),
      .valid     (skid_valid),
      .data      (skid_pkt)
   );

   // Stale payload stays in the main register after a drain or flush; masking hides it.
   assign out_valid = main_valid;
   assign out_data  = main_pkt[PKT_W-1 -: LANES_W];
   assign out_ctrl  = main_valid ? main_pkt[REG_W +: CTRL_W] : '0;
   assign out_wreg  = main_valid ? main_pkt[REG_W-1:0] : '0;

   always_comb begin
      case ({main_valid, skid_valid})
         2'b00:   occ = OCC_EMPTY;
         2'b11:   occ = OCC_FULL;
         default: occ = OCC_ONE;
      endcase
   end

   assign occupancy = occ;

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Bench for pipe_stage_latch: FIFO scoreboard on the default instance, lane mapping on a wide instance.
module tb_pipe_stage_latch;

   localparam int DW = 16;
   localparam int ND = 4;
   localparam int CW = 11;
   localparam int RW = 3;
   localparam int PW = ND * DW + CW + RW;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, flush, out_valid, out_ready;
   logic [ND*DW-1:0] in_data, out_data;
   logic [CW-1:0] in_ctrl, out_ctrl;
   logic [RW-1:0] in_wreg, out_wreg;
   logic [1:0]    occupancy;

   logic          w_in_valid, w_in_ready, w_flush, w_out_valid, w_out_ready;
   logic [63:0]   w_in_data, w_out_data;
   logic [3:0]    w_in_ctrl, w_out_ctrl;
   logic [2:0]    w_in_wreg, w_out_wreg;
   logic [1:0]    w_occupancy;

   logic [PW-1:0] exp_q[$];
   int            tests = 0;
   int            fails = 0;
   logic          acc_s;

   always #5 clk = ~clk;

   pipe_stage_latch dut (
      .clk (clk), .rst (rst),
      .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
      .in_ctrl (in_ctrl), .in_wreg (in_wreg), .flush (flush),
      .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
      .out_ctrl (out_ctrl), .out_wreg (out_wreg), .occupancy (occupancy)
   );

   pipe_stage_latch #(.DATA_W(32), .NUM_DATA(2), .CTRL_W(4), .REG_W(3)) dut_wide (
      .clk (clk), .rst (rst),
      .in_valid (w_in_valid), .in_ready (w_in_ready), .in_data (w_in_data),
      .in_ctrl (w_in_ctrl), .in_wreg (w_in_wreg), .flush (w_flush),
      .out_valid (w_out_valid), .out_ready (w_out_ready), .out_data (w_out_data),
      .out_ctrl (w_out_ctrl), .out_wreg (w_out_wreg), .occupancy (w_occupancy)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus; the expected packet is queued once the edge has accepted it.
   task automatic step(input logic v, input logic [ND*DW-1:0] d, input logic [CW-1:0] c,
                       input logic [RW-1:0] w, input logic ordy, input logic fl);
      in_valid  = v;
      in_data   = d;
      in_ctrl   = c;
      in_wreg   = w;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      acc_s = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (fl) exp_q.delete();
      else if (acc_s) exp_q.push_back({d, c, w});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b1, 1'b0);
   endtask

   function automatic logic [ND*DW-1:0] lanes(input logic [DW-1:0] l0);
      return {l0 ^ 16'hF000, l0 ^ 16'h0F00, l0 ^ 16'h00F0, l0};
   endfunction

   // Monitor: state the stage should be in follows from the expected queue alone.
   always @(negedge clk) begin
      if (rst) begin
         check("occupancy", occupancy, exp_q.size());
         check("in_ready", in_ready, exp_q.size() < 2);
         check("out_valid", out_valid, exp_q.size() != 0);
         if (exp_q.size() != 0) begin
            check("packet", {out_data, out_ctrl, out_wreg}, exp_q[0]);
            if (out_ready) void'(exp_q.pop_front());
         end else begin
            check("bubble_mask", {out_ctrl, out_wreg}, '0);
         end
      end
   end

   initial begin
      rst = 1'b0;
      in_valid = 1'b0; in_data = '0; in_ctrl = '0; in_wreg = '0;
      flush = 1'b0; out_ready = 1'b1;
      w_in_valid = 1'b0; w_in_data = '0; w_in_ctrl = '0; w_in_wreg = '0;
      w_flush = 1'b0; w_out_ready = 1'b1;
      #1;
      check("reset_occ", occupancy, 2'd0);
      check("reset_in_ready", in_ready, 1'b1);
      check("reset_out", {out_valid, out_ctrl, out_wreg, out_data}, '0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;

      // Streaming at full rate.
      for (int i = 1; i <= 3; i++) step(1'b1, lanes(16'(i)), 11'(i), 3'(i), 1'b1, 1'b0);
      idle(2);

      // Skid fill under stall, extra offer refused, then ordered release.
      step(1'b1, lanes(16'h1111), 11'h011, 3'd1, 1'b0, 1'b0);
      step(1'b1, lanes(16'h2222), 11'h022, 3'd2, 1'b0, 1'b0);
      step(1'b1, lanes(16'h9999), 11'h099, 3'd7, 1'b0, 1'b0);
      step(1'b1, lanes(16'h9999), 11'h099, 3'd7, 1'b0, 1'b0);
      idle(3);

      // Flush while full with a pending offer.
      step(1'b1, lanes(16'h1111), 11'h011, 3'd1, 1'b0, 1'b0);
      step(1'b1, lanes(16'h2222), 11'h022, 3'd2, 1'b0, 1'b0);
      step(1'b1, lanes(16'h3333), 11'h033, 3'd3, 1'b0, 1'b1);
      idle(2);

      // Flush with one entry while ready is high: the offer must be discarded.
      step(1'b1, lanes(16'h4444), 11'h044, 3'd4, 1'b0, 1'b0);
      step(1'b1, lanes(16'h5555), 11'h055, 3'd5, 1'b0, 1'b1);
      idle(1);

      // Flush coinciding with a drain: the visible packet still completes.
      step(1'b1, lanes(16'h6666), 11'h066, 3'd6, 1'b1, 1'b0);
      step(1'b0, '0, '0, '0, 1'b1, 1'b1);
      idle(1);

      // Bubble masking after an all-ones control word.
      step(1'b1, lanes(16'h7777), 11'h7FF, 3'd5, 1'b1, 1'b0);
      idle(3);

      // Asynchronous reset while full.
      step(1'b1, lanes(16'hAAAA), 11'h0AA, 3'd2, 1'b0, 1'b0);
      step(1'b1, lanes(16'hBBBB), 11'h0BB, 3'd3, 1'b0, 1'b0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_occ", occupancy, 2'd0);
      check("async_rst_in_ready", in_ready, 1'b1);
      check("async_rst_out", {out_valid, out_ctrl}, '0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      step(1'b1, lanes(16'hCCCC), 11'h0CC, 3'd4, 1'b1, 1'b0);
      idle(2);

      // Randomised traffic with occasional flush.
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(0, 1)), lanes(16'(16'h8000 + i)), 11'($urandom_range(0, 2047)),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
      end
      idle(3);

      // Wide instance lane mapping.
      w_in_valid = 1'b1;
      w_in_data  = {32'hCAFE_0002, 32'h1234_0001};
      w_in_ctrl  = 4'hA;
      w_in_wreg  = 3'd6;
      @(posedge clk);
      #1;
      w_in_valid = 1'b0;
      @(negedge clk);
      check("wide_lane1", w_out_data[63:32], 32'hCAFE_0002);
      check("wide_lane0", w_out_data[31:0], 32'h1234_0001);
      check("wide_ctrl_wreg", {w_out_valid, w_out_ctrl, w_out_wreg}, {1'b1, 4'hA, 3'd6});
      @(negedge clk);
      check("wide_bubble", {w_out_valid, w_out_ctrl, w_out_wreg, w_occupancy}, '0);

      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
